logic_tt_checker: RTL and testbench

- Sequential truth-table sweeper and response checker for a 2-input, 1-output combinational DUT.
- Drives every input vector onto the DUT, waits a programmable settle time, samples the DUT output and compares it against an expected truth table.
- Reports per-vector failures, an error count and a pass/fail flag.
- Sits on the opposite side of the DUT interface from the logic under test. It replaces free-running testbench stimulus with a synthesizable self-checking engine.

---
 rtl/logic_tt_checker.sv | 144 ++++++++++++++
 tb/tb_logic_tt_checker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_tt_checker.sv
// Truth-table sweeper for a 2-input, 1-output combinational DUT: steps {a,b} through
// 00..11, samples c_in SETTLE cycles after each vector and tallies mismatches.
module logic_tt_checker #(
  parameter logic [3:0]  EXP_TABLE = 4'b1110,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             loop_en,
  input  logic             c_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t           state_r, state_s;
  logic [1:0]       idx_r, idx_s;
  logic [3:0]       cnt_r, cnt_s;
  logic             a_s, b_s, busy_s, done_s, pass_s;
  logic [ERR_W-1:0] err_s, err_upd_s;
  logic [3:0]       fail_s, fail_upd_s;
  logic             mism_s;

  // Next-state and next-output decode for the sweep FSM.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    a_s        = a_out;
    b_s        = b_out;
    busy_s     = busy;
    done_s     = 1'b0;
    pass_s     = pass;
    err_s      = err_count;
    fail_s     = fail_vec;
    mism_s     = (c_in != EXP_TABLE[idx_r]);
    // Saturating tally: an all-ones count never wraps back to zero.
    err_upd_s  = (mism_s && !(&err_count)) ? (err_count + ERR_W'(1)) : err_count;
    fail_upd_s = fail_vec | (mism_s ? (4'b0001 << idx_r) : 4'b0000);

    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_s = RUN;
          idx_s   = 2'd0;
          cnt_s   = RELOAD;
          a_s     = 1'b0;
          b_s     = 1'b0;
          busy_s  = 1'b1;
          err_s   = {ERR_W{1'b0}};
          fail_s  = 4'b0000;
          pass_s  = 1'b0;
        end else begin
          a_s    = 1'b0;
          b_s    = 1'b0;
          busy_s = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
          idx_s   = 2'd0;
          cnt_s   = 4'd0;
          a_s     = 1'b0;
          b_s     = 1'b0;
          busy_s  = 1'b0;
        end else if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          err_s  = err_upd_s;
          fail_s = fail_upd_s;
          if (idx_r != 2'd3) begin
            idx_s      = idx_r + 2'd1;
            {a_s, b_s} = idx_r + 2'd1;
            cnt_s      = RELOAD;
          end else begin
            done_s = 1'b1;
            pass_s = (err_upd_s == {ERR_W{1'b0}});
            idx_s  = 2'd0;
            a_s    = 1'b0;
            b_s    = 1'b0;
            if (loop_en) begin
              cnt_s = RELOAD;
            end else begin
              state_s = IDLE;
              cnt_s   = 4'd0;
              busy_s  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 2'd0;
        cnt_s   = 4'd0;
        a_s     = 1'b0;
        b_s     = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= 2'd0;
      cnt_r     <= 4'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= {ERR_W{1'b0}};
      fail_vec  <= 4'b0000;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      cnt_r     <= cnt_s;
      a_out     <= a_s;
      b_out     <= b_s;
      busy      <= busy_s;
      done      <= done_s;
      pass      <= pass_s;
      err_count <= err_s;
      fail_vec  <= fail_s;
    end
  end

endmodule

// File: tb/tb_logic_tt_checker.sv
// Bench for logic_tt_checker: two instances (8-bit and 3-bit error counters) share stimulus;
// a timeline model predicts every output each cycle, plus hand-computed literal checks.
module tb_logic_tt_checker;
  localparam int S = 2;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic start   = 1'b0;
  logic abort   = 1'b0;
  logic loop_en = 1'b0;
  int   mode    = 0;   // 0: a|b, 1: stuck 0, 2: a&b, 3: stuck 1

  logic       c8, a8, b8, busy8, done8, pass8;
  logic       c3, a3, b3, busy3, done3, pass3;
  logic [7:0] err8;
  logic [2:0] err3;
  logic [3:0] fail8, fail3;

  logic [3:0] exp_tt = 4'b1110;
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  bit         m_active = 1'b0;
  bit         m_done   = 1'b0;
  bit         m_pass   = 1'b0;
  int         m_n      = 0;
  int         m_err    = 0;
  logic [3:0] m_fail   = 4'b0000;
  logic [1:0] m_vec    = 2'b00;

  always #5 clk = ~clk;

  function automatic logic dut_fn(int md, logic a, logic b);
    case (md)
      0:       return a | b;
      1:       return 1'b0;
      2:       return a & b;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  assign c8 = dut_fn(mode, a8, b8);
  assign c3 = dut_fn(mode, a3, b3);

  logic_tt_checker #(.EXP_TABLE(4'b1110), .SETTLE(S), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop_en(loop_en), .c_in(c8),
    .a_out(a8), .b_out(b8), .busy(busy8), .done(done8), .pass(pass8),
    .err_count(err8), .fail_vec(fail8));

  logic_tt_checker #(.EXP_TABLE(4'b1110), .SETTLE(S), .ERR_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop_en(loop_en), .c_in(c3),
    .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .fail_vec(fail3));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: edge n after the start edge; vector k is judged at n = (k+1)*S (mod sweep).
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0; m_done = 1'b0; m_pass = 1'b0;
      m_n = 0; m_err = 0; m_fail = 4'b0000; m_vec = 2'b00;
    end else if (!m_active) begin
      m_done = 1'b0;
      if (start && !abort) begin
        m_active = 1'b1; m_n = 0; m_err = 0; m_fail = 4'b0000; m_pass = 1'b0; m_vec = 2'b00;
      end
    end else begin
      m_done = 1'b0;
      m_n++;
      if (abort) begin
        m_active = 1'b0;
        m_vec    = 2'b00;
      end else begin
        if (m_n % S == 0) begin
          int k;
          logic [1:0] kv;
          k  = (m_n / S - 1) % 4;
          kv = 2'(k);
          if (dut_fn(mode, kv[1], kv[0]) != exp_tt[k]) begin
            m_err++;
            m_fail[k] = 1'b1;
          end
          if (k == 3) begin
            m_done = 1'b1;
            m_pass = (m_err == 0);
            if (!loop_en) m_active = 1'b0;
          end
        end
        m_vec = m_active ? 2'((m_n / S) % 4) : 2'b00;
      end
    end
  end

  // Per-cycle comparison of both instances against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("a8",    32'(a8),    32'(m_vec[1]));
      chk("b8",    32'(b8),    32'(m_vec[0]));
      chk("busy8", 32'(busy8), 32'(m_active));
      chk("done8", 32'(done8), 32'(m_done));
      chk("pass8", 32'(pass8), 32'(m_pass));
      chk("err8",  32'(err8),  32'(sat(m_err, 255)));
      chk("fail8", 32'(fail8), 32'(m_fail));
      chk("a3",    32'(a3),    32'(m_vec[1]));
      chk("b3",    32'(b3),    32'(m_vec[0]));
      chk("busy3", 32'(busy3), 32'(m_active));
      chk("done3", 32'(done3), 32'(m_done));
      chk("pass3", 32'(pass3), 32'(m_pass));
      chk("err3",  32'(err3),  32'(sat(m_err, 7)));
      chk("fail3", 32'(fail3), 32'(m_fail));
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done8 !== 1'b1 && cyc < 60);
    if (done8 !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done within %0d cycles", cyc);
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_ab",   32'({a8, b8}), 32'd0);
    chk("rst_err",  32'(err8), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // 1: matching DUT
    mode = 0;
    do_start();
    chk("t1_ab0", 32'({a8, b8}), 32'd0);
    repeat (2) @(negedge clk);
    chk("t1_ab1", 32'({a8, b8}), 32'd1);
    repeat (2) @(negedge clk);
    chk("t1_ab2", 32'({a8, b8}), 32'd2);
    repeat (2) @(negedge clk);
    chk("t1_ab3", 32'({a8, b8}), 32'd3);
    wait_done(cyc);
    chk("t1_done_at_E8", 32'(cyc), 32'd2);
    chk("t1_busy", 32'(busy8), 32'd0);
    chk("t1_pass", 32'(pass8), 32'd1);
    chk("t1_err",  32'(err8),  32'd0);
    chk("t1_fail", 32'(fail8), 32'd0);
    @(negedge clk);

    // 2: stuck at 0
    mode = 1;
    do_start();
    wait_done(cyc);
    chk("t2_lat",  32'(cyc),   32'd8);
    chk("t2_err",  32'(err8),  32'd3);
    chk("t2_fail", 32'(fail8), 32'b1110);
    chk("t2_pass", 32'(pass8), 32'd0);
    @(negedge clk);

    // 3: a&b
    mode = 2;
    do_start();
    wait_done(cyc);
    chk("t3_fail", 32'(fail8), 32'b0110);
    chk("t3_err",  32'(err8),  32'd2);
    chk("t3_pass", 32'(pass8), 32'd0);
    @(negedge clk);

    // 4: abort at E3 (stuck at 1, so idx0 mismatches before the abort)
    mode = 3;
    do_start();
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_busy", 32'(busy8), 32'd0);
    chk("t4_ab",   32'({a8, b8}), 32'd0);
    chk("t4_err",  32'(err8),  32'd1);
    chk("t4_fail", 32'(fail8), 32'b0001);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8 === 1'b1) pulses++;
    end
    chk("t4_no_done", 32'(pulses), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t4_start_abort_busy", 32'(busy8), 32'd0);
    mode = 0;
    do_start();
    chk("t4_cleared", 32'(err8), 32'd0);
    wait_done(cyc);
    chk("t4_pass", 32'(pass8), 32'd1);
    chk("t4_fail2", 32'(fail8), 32'd0);
    @(negedge clk);

    // 5: loop, saturating 3-bit counter
    mode    = 1;
    loop_en = 1'b1;
    do_start();
    wait_done(cyc);
    chk("t5_lat1", 32'(cyc), 32'd8);
    chk("t5_err3_1", 32'(err3), 32'd3);
    wait_done(cyc);
    chk("t5_lat2", 32'(cyc), 32'd8);
    chk("t5_err3_2", 32'(err3), 32'd6);
    wait_done(cyc);
    chk("t5_lat3", 32'(cyc), 32'd8);
    chk("t5_err3_3", 32'(err3), 32'd7);
    chk("t5_err8_3", 32'(err8), 32'd9);
    chk("t5_fail3", 32'(fail3), 32'b1110);
    chk("t5_busy_loop", 32'(busy8), 32'd1);
    loop_en = 1'b0;
    wait_done(cyc);
    chk("t5_err3_4", 32'(err3), 32'd7);
    chk("t5_err8_4", 32'(err8), 32'd12);
    chk("t5_busy_end", 32'(busy8), 32'd0);
    @(negedge clk);

    // 6: asynchronous reset between edges
    mode = 0;
    do_start();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy8), 32'd0);
    chk("t6_ab",   32'({a8, b8, a3, b3}), 32'd0);
    chk("t6_misc", 32'({done8, pass8, fail8, err8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_idle", 32'(busy8), 32'd0);
    do_start();
    wait_done(cyc);
    chk("t6_lat",  32'(cyc),   32'd8);
    chk("t6_pass", 32'(pass8), 32'd1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, expected completion");
    $fatal(1);
  end

endmodule
